riscv_apu_resp: RTL and testbench

- Responder (slave) end of the APU interconnect. It accepts requests from the APU dispatcher over a req/gnt handshake, executes a small integer op set with a latency chosen by the request's latency class, and returns results strictly in order over a valid/ready channel.
- Guarantees the ordering the dispatcher relies on: a later request never returns before an earlier one.
- Holds at most 2 outstanding results in pipeline stages st2→st1, plus one multicycle slot.

---
 rtl/riscv_apu_resp.sv | 150 +++++++++++++++
 tb/tb_riscv_apu_resp.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_apu_resp.sv
// APU responder: accepts requests over req/gnt, computes a small integer op at
// grant time, and returns results in order through a two-stage pipeline
// (st2 -> st1) plus one multicycle slot for long-latency requests.
//
// Handshakes:
//   request : a transfer happens when apu_slave_req_i & apu_slave_gnt_o. The
//             payload must stay stable until granted. gnt never depends on
//             req except through the final AND.
//   result  : st1 is presented on valid/result/flags and is consumed when
//             apu_slave_valid_o & apu_slave_ready_i. Once valid is high, the
//             valid, result and flags outputs hold until consumed.
module riscv_apu_resp #(
   parameter int WOP          = 32,
   parameter int MULTI_CYCLES = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           apu_slave_req_i,
   output logic           apu_slave_gnt_o,
   input  logic [2:0]     apu_slave_op_i,
   input  logic [1:0]     apu_slave_lat_i,
   input  logic [WOP-1:0] apu_slave_operands_0_i,
   input  logic [WOP-1:0] apu_slave_operands_1_i,
   input  logic [WOP-1:0] apu_slave_operands_2_i,
   output logic           apu_slave_valid_o,
   input  logic           apu_slave_ready_i,
   output logic [WOP-1:0] apu_slave_result_o,
   output logic [1:0]     apu_slave_flags_o,
   output logic           busy_o
);

   localparam int CW = 4;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_CYCLES - 1);

   // Output stage (st1), middle stage (st2) and the multicycle slot
   logic           st1_v, st2_v, mc_v;
   logic [WOP-1:0] st1_res, st2_res, mc_res;
   logic [1:0]     st1_flg, st2_flg, mc_flg;
   logic [CW-1:0]  mc_cnt;

   logic           stall, accept, gnt, mc_done;
   logic           new_short, new_mid, new_long;
   logic [WOP-1:0] new_res, prod;
   logic           new_illegal;
   logic [1:0]     new_flg;

   // Compute the result and flags of the request currently on the inputs
   always_comb begin
      new_res     = '0;
      new_illegal = 1'b0;
      prod        = apu_slave_operands_0_i * apu_slave_operands_1_i;
      case (apu_slave_op_i)
         3'd0: new_res = apu_slave_operands_0_i + apu_slave_operands_1_i;
         3'd1: new_res = apu_slave_operands_0_i - apu_slave_operands_1_i;
         3'd2: new_res = prod;
         3'd3: new_res = prod + apu_slave_operands_2_i;
         3'd4: new_res = ($signed(apu_slave_operands_0_i) < $signed(apu_slave_operands_1_i)) ?
                         apu_slave_operands_0_i : apu_slave_operands_1_i;
         3'd5: new_res = ($signed(apu_slave_operands_0_i) > $signed(apu_slave_operands_1_i)) ?
                         apu_slave_operands_0_i : apu_slave_operands_1_i;
         default: begin
            new_res     = '0;
            new_illegal = 1'b1;
         end
      endcase
      new_flg = {(new_res == '0), new_illegal};
   end

   // Decide whether a request of the presented latency class can be taken.
   // Short (lat 0/1) and long (lat 3) requests need st2 empty so they cannot
   // overtake a lat 2 request granted the cycle before; nothing is taken while
   // the multicycle slot is busy, which keeps completions in order.
   always_comb begin
      stall   = st1_v & ~apu_slave_ready_i;
      mc_done = mc_v & (mc_cnt == CW'(1));
      accept  = 1'b0;
      if (!rst_i && !stall && !mc_v) begin
         accept = (apu_slave_lat_i == 2'd2) ? 1'b1 : ~st2_v;
      end
      gnt       = apu_slave_req_i & accept;
      new_short = gnt & (apu_slave_lat_i < 2'd2);
      new_mid   = gnt & (apu_slave_lat_i == 2'd2);
      new_long  = gnt & (apu_slave_lat_i == 2'd3);
   end

   // Output stage: multicycle completion wins, then a new short request, then st2
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st1_v   <= 1'b0;
         st1_res <= '0;
         st1_flg <= '0;
      end else if (!stall) begin
         if (mc_done) begin
            st1_v   <= 1'b1;
            st1_res <= mc_res;
            st1_flg <= mc_flg;
         end else if (new_short) begin
            st1_v   <= 1'b1;
            st1_res <= new_res;
            st1_flg <= new_flg;
         end else begin
            st1_v   <= st2_v;
            st1_res <= st2_res;
            st1_flg <= st2_flg;
         end
      end
   end

   // Middle stage: holds a lat 2 request for one extra cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st2_v   <= 1'b0;
         st2_res <= '0;
         st2_flg <= '0;
      end else if (!stall) begin
         st2_v   <= new_mid;
         st2_res <= new_mid ? new_res : '0;
         st2_flg <= new_mid ? new_flg : '0;
      end
   end

   // Multicycle slot: load on a lat 3 grant, count down, free on completion
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mc_v   <= 1'b0;
         mc_res <= '0;
         mc_flg <= '0;
         mc_cnt <= '0;
      end else if (!stall) begin
         if (new_long) begin
            mc_v   <= 1'b1;
            mc_res <= new_res;
            mc_flg <= new_flg;
            mc_cnt <= CNT_LOAD;
         end else if (mc_done) begin
            mc_v   <= 1'b0;
            mc_cnt <= '0;
         end else if (mc_v) begin
            mc_cnt <= mc_cnt - CW'(1);
         end
      end
   end

   assign apu_slave_gnt_o    = gnt;
   assign apu_slave_valid_o  = st1_v;
   assign apu_slave_result_o = st1_res;
   assign apu_slave_flags_o  = st1_flg;
   assign busy_o             = st1_v | st2_v | mc_v;

endmodule

// File: tb/tb_riscv_apu_resp.sv
// Bench for riscv_apu_resp: directed scenarios plus a randomized phase,
// checked against an op-level model and an in-order expected queue.
module tb_riscv_apu_resp;

   localparam int WOP = 32;
   localparam int MC  = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic           req, gnt, valid, ready, busy;
   logic [2:0]     op;
   logic [1:0]     lat;
   logic [WOP-1:0] a, b, c, res;
   logic [1:0]     flags;

   riscv_apu_resp #(.WOP(WOP), .MULTI_CYCLES(MC)) dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .apu_slave_req_i        (req),
      .apu_slave_gnt_o        (gnt),
      .apu_slave_op_i         (op),
      .apu_slave_lat_i        (lat),
      .apu_slave_operands_0_i (a),
      .apu_slave_operands_1_i (b),
      .apu_slave_operands_2_i (c),
      .apu_slave_valid_o      (valid),
      .apu_slave_ready_i      (ready),
      .apu_slave_result_o     (res),
      .apu_slave_flags_o      (flags),
      .busy_o                 (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: {flags, result} expected in grant order
   logic [WOP+1:0] exp_q[$];
   logic [WOP+1:0] got_log[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: op semantics in plain 64-bit arithmetic
   function automatic logic [WOP+1:0] model(input logic [2:0] o, input logic [WOP-1:0] xa,
                                            input logic [WOP-1:0] xb, input logic [WOP-1:0] xc);
      logic [63:0]    wide;
      logic [WOP-1:0] r;
      logic           ill;
      ill  = 1'b0;
      wide = 64'(xa) * 64'(xb);
      case (o)
         3'd0: r = xa + xb;
         3'd1: r = xa - xb;
         3'd2: r = wide[WOP-1:0];
         3'd3: begin wide = wide + 64'(xc); r = wide[WOP-1:0]; end
         3'd4: r = (int'(xa) < int'(xb)) ? xa : xb;
         3'd5: r = (int'(xa) > int'(xb)) ? xa : xb;
         default: begin r = '0; ill = 1'b1; end
      endcase
      return {(r == '0), ill, r};
   endfunction

   // Monitor at the inactive edge: occupancy, hold-while-stalled, ordering
   logic           prev_stall = 1'b0;
   logic [WOP-1:0] prev_res;
   logic [1:0]     prev_flg;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         check("busy", 64'(busy), 64'(exp_q.size() != 0));
         if (prev_stall) begin
            check("hold_valid", 64'(valid), 64'd1);
            check("hold_result", 64'(res), 64'(prev_res));
            check("hold_flags", 64'(flags), 64'(prev_flg));
         end
         if (valid && !ready) check("gnt_in_stall", 64'(gnt), 64'd0);
         if (valid && ready) begin
            got_log.push_back({flags, res});
            if (exp_q.size() == 0) check("unexpected_result", 64'({flags, res}), 64'h3_dead_beef);
            else check("result", 64'({flags, res}), 64'(exp_q.pop_front()));
         end
         if (req && gnt) exp_q.push_back(model(op, a, b, c));
         prev_stall = valid && !ready;
         prev_res   = res;
         prev_flg   = flags;
      end
   end

   // driver: called at posedge+1; holds the payload until granted
   task automatic send(input logic [2:0] o, input logic [1:0] l, input logic [WOP-1:0] xa,
                       input logic [WOP-1:0] xb, input logic [WOP-1:0] xc, output int waited);
      req = 1'b1; op = o; lat = l; a = xa; b = xb; c = xc;
      waited = 0;
      @(negedge clk);
      while (!gnt && waited < 300) begin
         waited++;
         @(negedge clk);
      end
      if (!gnt) check("gnt_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   // count inactive edges until valid is seen
   task automatic wait_valid(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!valid && cyc < 100);
   endtask

   // wait until every granted request has been returned; ends at posedge+1
   task automatic wait_drain();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (exp_q.size() != 0 && n < 400);
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_log(input string tag, input int idx, input logic [WOP+1:0] exp);
      logic [WOP+1:0] got;
      got = '1;
      if (idx < got_log.size()) got = got_log[idx];
      check(tag, 64'(got), 64'(exp));
   endtask

   function automatic logic [WOP-1:0] pick_val();
      case ($urandom_range(0, 4))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return WOP'($urandom_range(0, 10));
         default: return WOP'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   bit rand_done;

   initial begin
      int w, cyc, wtot, seen;
      rst = 1'b1; req = 1'b1; op = '0; lat = '0; a = '0; b = '0; c = '0; ready = 1'b1;
      #3;
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_result", 64'(res), 64'd0);
      check("rst_flags", 64'(flags), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_gnt", 64'(gnt), 64'd0);
      req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // lat 0 ADD
      got_log.delete();
      send(3'd0, 2'd0, 32'd5, 32'd7, 32'd0, w);
      check("add_gnt_wait", 64'(w), 64'd0);
      wait_valid(cyc);
      check("add_latency", 64'(cyc), 64'd1);
      wait_drain();
      check_log("add_result", 0, {2'b00, 32'd12});
      @(negedge clk);
      check("add_busy_after", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // lat 2 MUL followed by lat 0 SUB: the SUB must wait one cycle
      got_log.delete();
      send(3'd2, 2'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, w);
      check("mul_gnt_wait", 64'(w), 64'd0);
      send(3'd1, 2'd0, 32'd3, 32'd3, 32'd0, w);
      check("sub_gnt_wait", 64'(w), 64'd1);
      wait_drain();
      check_log("mul_result", 0, {2'b00, 32'hFFFF_FFFE});
      check_log("sub_result", 1, {2'b10, 32'h0});

      // lat 3 MAC latency, then a follow-up request blocked by the slot
      got_log.delete();
      send(3'd3, 2'd3, 32'd3, 32'd4, 32'd5, w);
      wait_valid(cyc);
      check("mac_latency", 64'(cyc), 64'(MC));
      wait_drain();
      send(3'd3, 2'd3, 32'd3, 32'd4, 32'd5, w);
      send(3'd0, 2'd0, 32'd1, 32'd1, 32'd0, w);
      check("blocked_by_slot_wait", 64'(w), 64'(MC - 1));
      wait_drain();
      check_log("mac_result", 0, {2'b00, 32'd17});
      check_log("mac_result2", 1, {2'b00, 32'd17});
      check_log("after_mac_result", 2, {2'b00, 32'd2});

      // stream of lat 2 ADDs with ready low for 3 cycles mid-stream
      got_log.delete();
      wtot = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send(3'd0, 2'd2, WOP'(i * 100 + 1), WOP'(i + 10), 32'd0, w);
               wtot += w;
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 ready = 1'b1;
         end
      join
      check("stream_gnt_dropped", 64'(wtot > 0), 64'd1);
      wait_drain();
      check("stream_count", 64'(got_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) check_log("stream_sum", i, {2'b00, WOP'(101 * i + 11)});

      // illegal ops and signed min/max
      got_log.delete();
      send(3'd6, 2'd1, 32'd9, 32'd9, 32'd9, w);
      send(3'd7, 2'd2, 32'd1, 32'd2, 32'd3, w);
      send(3'd4, 2'd0, 32'h8000_0000, 32'd1, 32'd0, w);
      send(3'd5, 2'd0, 32'h8000_0000, 32'd1, 32'd0, w);
      wait_drain();
      check_log("op6", 0, {2'b11, 32'h0});
      check_log("op7", 1, {2'b11, 32'h0});
      check_log("min", 2, {2'b00, 32'h8000_0000});
      check_log("max", 3, {2'b00, 32'h1});

      // asynchronous reset with the multicycle slot, then st2, occupied
      for (int s = 0; s < 2; s++) begin
         if (s == 0) send(3'd3, 2'd3, 32'd2, 32'd2, 32'd2, w);
         else        send(3'd0, 2'd2, 32'd2, 32'd2, 32'd2, w);
         if (s == 0) @(negedge clk);
         #2;
         check("pre_rst_busy", 64'(busy), 64'd1);
         req = 1'b1; lat = 2'd0; op = 3'd0;
         rst = 1'b1;
         #1;
         check("async_rst_valid", 64'(valid), 64'd0);
         check("async_rst_busy", 64'(busy), 64'd0);
         check("async_rst_gnt", 64'(gnt), 64'd0);
         @(negedge clk);
         req = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         seen = 0;
         repeat (10) begin
            @(negedge clk);
            if (valid) seen++;
         end
         check("no_stale_result", 64'(seen), 64'd0);
         @(posedge clk); #1;
      end

      // randomized traffic with random backpressure
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    pick_val(), pick_val(), pick_val(), w);
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 3)) begin
                     @(posedge clk); #1;
                  end
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               ready = ($urandom_range(0, 3) != 0);
            end
            ready = 1'b1;
         end
      join
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
